buffer_access_arbiter: RTL and testbench
========================================

BUFFER_ACCESS_ARBITER -- requirements
Module: buffer_access_arbiter

Interface
REQ-001 The block SHALL have parameter BUF_DEPTH, default 64, which is the maximum endpoint data-buffer byte count.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 nRst  in  1  reset, asynchronous, active-low.
REQ-004 txPacketSizeChanged  in  1  one-cycle pulse; the AHB host wrote a new TX packet size.
REQ-005 txPacketDataSize  in  7  TX packet byte count; sampled only when txPacketSizeChanged=1.
REQ-006 rxPacketStart  in  1  one-cycle pulse; the USB RX side began an OUT data packet.
REQ-007 rxPacketDone  in  1  one-cycle pulse; the RX packet ended with good CRC.
REQ-008 rxPacketError  in  1  one-cycle pulse; the RX packet was aborted (CRC or bitstuff error).
REQ-009 txStart  in  1  one-cycle pulse; the USB TX side received an IN token.
REQ-010 txTransferDone  in  1  one-cycle pulse; the USB TX side finished sending the buffer.
REQ-011 bufferOccupancy  in  7  current FIFO byte count, 0..BUF_DEPTH.
REQ-012 flush  in  1  software clear request, level-sampled.
REQ-013 ahbGrant, usbRxGrant, usbTxGrant  out  1 each  buffer-port ownership; at most one is high at a time.
REQ-014 bufferReserved  out  1  high in every state except IDLE.
REQ-015 txPacketReady  out  1  high in TX_WAIT and TX_DRAIN.
REQ-016 rxDataReady  out  1  high in AHB_DRAIN.
REQ-017 nakOut  out  1  one-cycle pulse; the USB side SHALL NAK the current token.
REQ-018 bufferFlush  out  1  one-cycle pulse; the FIFO SHALL clear its contents.
REQ-019 pendingTx  out  1  a TX size request is latched but not yet serviced.

Function
REQ-020 The FSM SHALL have the states IDLE, AHB_FILL, TX_WAIT, TX_DRAIN, RX_FILL and AHB_DRAIN, and outputs SHALL be decoded from the registered state (Moore).
REQ-021 Grants SHALL be decoded from state as follows: ahbGrant in AHB_FILL and AHB_DRAIN; usbRxGrant in RX_FILL; usbTxGrant in TX_DRAIN; all grants 0 in IDLE and TX_WAIT.
REQ-022 In IDLE, rxPacketStart SHALL go to RX_FILL; otherwise txPacketSizeChanged or pendingTx SHALL go to AHB_FILL and clear pendingTx; otherwise the FSM SHALL stay in IDLE.
REQ-023 If rxPacketStart and txPacketSizeChanged occur together in IDLE, RX SHALL win and pendingTx SHALL be set.
REQ-024 txPacketDataSize SHALL be latched into a 7-bit size register on every txPacketSizeChanged, in any state.
REQ-025 Values above BUF_DEPTH SHALL be clamped to BUF_DEPTH when latched.
REQ-026 AHB_FILL SHALL go to TX_WAIT when bufferOccupancy equals the latched size, so a size of 0 leaves AHB_FILL after one cycle (zero-length packet).
REQ-027 TX_WAIT SHALL go to TX_DRAIN on txStart.
REQ-028 TX_DRAIN SHALL go to IDLE on txTransferDone.
REQ-029 RX_FILL SHALL go to AHB_DRAIN on rxPacketDone.
REQ-030 RX_FILL SHALL go to IDLE on rxPacketError and pulse bufferFlush.
REQ-031 If rxPacketDone and rxPacketError occur in the same cycle, the error SHALL win.
REQ-032 AHB_DRAIN SHALL go to IDLE when bufferOccupancy equals 0.
REQ-033 txPacketSizeChanged in any non-IDLE state SHALL set pendingTx.
REQ-034 rxPacketStart in any state other than IDLE SHALL pulse nakOut and leave the state unchanged.
REQ-035 txStart in any state other than TX_WAIT or TX_DRAIN SHALL pulse nakOut and leave the state unchanged.
REQ-036 flush SHALL have highest priority: the next state SHALL be IDLE, bufferFlush SHALL pulse, and pendingTx SHALL clear.
REQ-037 flush SHALL override a simultaneous txPacketSizeChanged, so pendingTx ends at 0.
REQ-038 nakOut and bufferFlush SHALL be registered and assert the cycle after the causing event.
REQ-039 Back-to-back events SHALL produce back-to-back pulses.
REQ-040 Occupancy and size comparisons SHALL be unsigned 7-bit equality.

Reset
REQ-041 Reset SHALL force: state IDLE, size register 0, pendingTx 0, nakOut 0, bufferFlush 0, all grants 0, bufferReserved 0, txPacketReady 0, rxDataReady 0.
REQ-042 Reset asserted mid-transfer SHALL abort the transfer immediately; no bufferFlush SHALL be issued, because the FIFO is reset by the same nRst.

Structure
REQ-043 The shared package usb_buf_pkg SHALL hold the state enum type bufState_t (3 bits) and the constant BUF_DEPTH_DEFAULT = 64.
REQ-044 The block SHALL be a single module with no sub-modules; the next-state logic, state/size/pending registers and pulse registers SHALL be separate processes.

Verification
REQ-045 Size 8: txPacketSizeChanged with size=8, occupancy ramps 0->8, then txStart, then txTransferDone -> states AHB_FILL -> TX_WAIT -> TX_DRAIN -> IDLE; ahbGrant high until occupancy=8.
REQ-046 Simultaneous events: rxPacketStart and txPacketSizeChanged(size=16) in the same IDLE cycle -> RX_FILL with pendingTx=1; after rxPacketDone and occupancy reaching 0 -> AHB_FILL with latched size 16.
REQ-047 RX abort: rxPacketError during RX_FILL with occupancy=12 -> IDLE next cycle; bufferFlush pulses once; no rxDataReady.
REQ-048 Clamp and zero-length: size=100 -> latched size 64; size=0 -> AHB_FILL for one cycle, then TX_WAIT.
REQ-049 Conflicts: rxPacketStart during AHB_FILL, or txStart in IDLE -> single nakOut pulse each; state unchanged.
REQ-050 Flush and reset: flush in TX_DRAIN -> IDLE, bufferFlush pulses, pendingTx=0; nRst low mid-RX_FILL -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/usb_buf_pkg.sv
// Shared types for the USB endpoint buffer logic.
// Holds the arbiter state encoding and the default buffer depth.
package usb_buf_pkg;

  localparam int BUF_DEPTH_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AHB_FILL  = 3'd1,
    TX_WAIT   = 3'd2,
    TX_DRAIN  = 3'd3,
    RX_FILL   = 3'd4,
    AHB_DRAIN = 3'd5
  } bufState_t;

endpackage

// File: rtl/buffer_access_arbiter.sv
// Arbitrates ownership of the endpoint data buffer between the AHB host
// and the USB RX/TX engines; Moore FSM with registered NAK/flush pulses.
module buffer_access_arbiter
  import usb_buf_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       txPacketSizeChanged,
  input  logic [6:0] txPacketDataSize,
  input  logic       rxPacketStart,
  input  logic       rxPacketDone,
  input  logic       rxPacketError,
  input  logic       txStart,
  input  logic       txTransferDone,
  input  logic [6:0] bufferOccupancy,
  input  logic       flush,
  output logic       ahbGrant,
  output logic       usbRxGrant,
  output logic       usbTxGrant,
  output logic       bufferReserved,
  output logic       txPacketReady,
  output logic       rxDataReady,
  output logic       nakOut,
  output logic       bufferFlush,
  output logic       pendingTx
);

  localparam logic [6:0] DEPTH_MAX = 7'(BUF_DEPTH);

  bufState_t  state;
  bufState_t  stateNext;
  logic [6:0] sizeReg;
  logic [6:0] sizeClamped;
  logic       pendingNext;
  logic       nakNext;
  logic       flushNext;

  assign sizeClamped = (txPacketDataSize > DEPTH_MAX) ? DEPTH_MAX : txPacketDataSize;

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    stateNext   = state;
    pendingNext = pendingTx | txPacketSizeChanged;
    if (flush) begin
      stateNext   = IDLE;
      pendingNext = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rxPacketStart) begin
            stateNext = RX_FILL;
          end else if (txPacketSizeChanged || pendingTx) begin
            stateNext   = AHB_FILL;
            pendingNext = 1'b0;
          end
        end
        AHB_FILL:  if (bufferOccupancy == sizeReg) stateNext = TX_WAIT;
        TX_WAIT:   if (txStart) stateNext = TX_DRAIN;
        TX_DRAIN:  if (txTransferDone) stateNext = IDLE;
        RX_FILL: begin
          // An aborted packet outranks a simultaneous good-CRC report.
          if (rxPacketError)     stateNext = IDLE;
          else if (rxPacketDone) stateNext = AHB_DRAIN;
        end
        AHB_DRAIN: if (bufferOccupancy == 7'd0) stateNext = IDLE;
        default:   stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    nakNext   = (rxPacketStart && (state != IDLE)) ||
                (txStart && (state != TX_WAIT) && (state != TX_DRAIN));
    flushNext = flush || ((state == RX_FILL) && rxPacketError);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      sizeReg   <= 7'd0;
      pendingTx <= 1'b0;
    end else begin
      state     <= stateNext;
      pendingTx <= pendingNext;
      if (txPacketSizeChanged) sizeReg <= sizeClamped;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      nakOut      <= 1'b0;
      bufferFlush <= 1'b0;
    end else begin
      nakOut      <= nakNext;
      bufferFlush <= flushNext;
    end
  end

  // Decoded from the registered state only, so reset clears them asynchronously.
  assign ahbGrant       = (state == AHB_FILL) || (state == AHB_DRAIN);
  assign usbRxGrant     = (state == RX_FILL);
  assign usbTxGrant     = (state == TX_DRAIN);
  assign bufferReserved = (state != IDLE);
  assign txPacketReady  = (state == TX_WAIT) || (state == TX_DRAIN);
  assign rxDataReady    = (state == AHB_DRAIN);

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Self-checking bench: directed vector table, reset corner cases, then
// randomized traffic compared against a rule-level reference model.
module tb_buffer_access_arbiter;

  logic       clk = 1'b0;
  logic       nRst;
  logic       txPacketSizeChanged;
  logic [6:0] txPacketDataSize;
  logic       rxPacketStart;
  logic       rxPacketDone;
  logic       rxPacketError;
  logic       txStart;
  logic       txTransferDone;
  logic [6:0] bufferOccupancy;
  logic       flush;
  logic       ahbGrant, usbRxGrant, usbTxGrant;
  logic       bufferReserved, txPacketReady, rxDataReady;
  logic       nakOut, bufferFlush, pendingTx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buffer_access_arbiter #(.BUF_DEPTH(64)) dut (
    .clk                 (clk),
    .nRst                (nRst),
    .txPacketSizeChanged (txPacketSizeChanged),
    .txPacketDataSize    (txPacketDataSize),
    .rxPacketStart       (rxPacketStart),
    .rxPacketDone        (rxPacketDone),
    .rxPacketError       (rxPacketError),
    .txStart             (txStart),
    .txTransferDone      (txTransferDone),
    .bufferOccupancy     (bufferOccupancy),
    .flush               (flush),
    .ahbGrant            (ahbGrant),
    .usbRxGrant          (usbRxGrant),
    .usbTxGrant          (usbTxGrant),
    .bufferReserved      (bufferReserved),
    .txPacketReady       (txPacketReady),
    .rxDataReady         (rxDataReady),
    .nakOut              (nakOut),
    .bufferFlush         (bufferFlush),
    .pendingTx           (pendingTx)
  );

  // Observed vector: {ahb, usbRx, usbTx, reserved, txReady, rxReady, nak, bufFlush, pending}
  logic [8:0] obs;
  assign obs = {ahbGrant, usbRxGrant, usbTxGrant, bufferReserved, txPacketReady,
                rxDataReady, nakOut, bufferFlush, pendingTx};

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_AF   = 6'b100100;
  localparam logic [5:0] S_TW   = 6'b000110;
  localparam logic [5:0] S_TD   = 6'b001110;
  localparam logic [5:0] S_RF   = 6'b010100;
  localparam logic [5:0] S_AD   = 6'b100101;

  typedef struct {
    string      name;
    logic       tpsc;
    logic [6:0] size;
    logic       rxs, rxd, rxe, txs, txd;
    logic [6:0] occ;
    logic       fl;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic tpsc, logic [6:0] size, logic rxs, logic rxd,
                              logic rxe, logic txs, logic txd, logic [6:0] occ, logic fl,
                              logic [5:0] st, logic [2:0] pulses);
    vec_t v;
    v.name = n; v.tpsc = tpsc; v.size = size; v.rxs = rxs; v.rxd = rxd; v.rxe = rxe;
    v.txs = txs; v.txd = txd; v.occ = occ; v.fl = fl; v.exp = {st, pulses};
    return v;
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (ahb,rx,tx,rsv,txRdy,rxRdy,nak,bflush,pend) t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(logic tpsc, logic [6:0] size, logic rxs, logic rxd, logic rxe,
                       logic txs, logic txd, logic [6:0] occ, logic fl);
    txPacketSizeChanged = tpsc;
    txPacketDataSize    = size;
    rxPacketStart       = rxs;
    rxPacketDone        = rxd;
    rxPacketError       = rxe;
    txStart             = txs;
    txTransferDone      = txd;
    bufferOccupancy     = occ;
    flush               = fl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
  endtask

  // Reference model: state names are the bench's own, transitions follow the written rules.
  typedef enum {M_IDLE, M_AHB_FILL, M_TX_WAIT, M_TX_DRAIN, M_RX_FILL, M_AHB_DRAIN} mstate_e;

  function automatic logic [5:0] state_view(mstate_e m);
    case (m)
      M_AHB_FILL:  return S_AF;
      M_TX_WAIT:   return S_TW;
      M_TX_DRAIN:  return S_TD;
      M_RX_FILL:   return S_RF;
      M_AHB_DRAIN: return S_AD;
      default:     return S_IDLE;
    endcase
  endfunction

  mstate_e mState;
  int      mSize;
  bit      mPend, mNak, mBfl;

  task automatic model_step(bit tpsc, int size, bit rxs, bit rxd, bit rxe, bit txs, bit txd,
                            int occ, bit fl);
    mstate_e nxt = mState;
    bit      pend = mPend || tpsc;
    mNak = (rxs && mState != M_IDLE) ||
           (txs && !(mState == M_TX_WAIT || mState == M_TX_DRAIN));
    mBfl = fl || (mState == M_RX_FILL && rxe);
    if (fl) begin
      nxt  = M_IDLE;
      pend = 0;
    end else if (mState == M_IDLE) begin
      if (rxs) nxt = M_RX_FILL;
      else if (tpsc || mPend) begin nxt = M_AHB_FILL; pend = 0; end
    end else if (mState == M_AHB_FILL && occ == mSize) nxt = M_TX_WAIT;
    else if (mState == M_TX_WAIT && txs) nxt = M_TX_DRAIN;
    else if (mState == M_TX_DRAIN && txd) nxt = M_IDLE;
    else if (mState == M_RX_FILL && rxe) nxt = M_IDLE;
    else if (mState == M_RX_FILL && rxd) nxt = M_AHB_DRAIN;
    else if (mState == M_AHB_DRAIN && occ == 0) nxt = M_IDLE;
    if (tpsc) mSize = (size > 64) ? 64 : size;
    mState = nxt;
    mPend  = pend;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //            name         tpsc size rxs rxd rxe txs txd occ fl  state   nak/bfl/pend
    vecs.push_back(mk("s8_start",  1, 8,  0,0,0,0,0, 0,  0, S_AF,   3'b000));
    vecs.push_back(mk("s8_occ4",   0, 0,  0,0,0,0,0, 4,  0, S_AF,   3'b000));
    vecs.push_back(mk("s8_full",   0, 0,  0,0,0,0,0, 8,  0, S_TW,   3'b000));
    vecs.push_back(mk("s8_txs",    0, 0,  0,0,0,1,0, 8,  0, S_TD,   3'b000));
    vecs.push_back(mk("s8_drain",  0, 0,  0,0,0,0,0, 8,  0, S_TD,   3'b000));
    vecs.push_back(mk("s8_done",   0, 0,  0,0,0,0,1, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("nak_txs",   0, 0,  0,0,0,1,0, 0,  0, S_IDLE, 3'b100));
    vecs.push_back(mk("nak_clr",   0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("s4_start",  1, 4,  0,0,0,0,0, 0,  0, S_AF,   3'b000));
    vecs.push_back(mk("nak_rxs",   0, 0,  1,0,0,0,0, 2,  0, S_AF,   3'b100));
    vecs.push_back(mk("s4_occ3",   0, 0,  0,0,0,0,0, 3,  0, S_AF,   3'b000));
    vecs.push_back(mk("s4_full",   0, 0,  0,0,0,0,0, 4,  0, S_TW,   3'b000));
    vecs.push_back(mk("s4_txs",    0, 0,  0,0,0,1,0, 4,  0, S_TD,   3'b000));
    vecs.push_back(mk("s4_done",   0, 0,  0,0,0,0,1, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("sim_rx_tx", 1, 16, 1,0,0,0,0, 0,  0, S_RF,   3'b001));
    vecs.push_back(mk("sim_fill",  0, 0,  0,0,0,0,0, 10, 0, S_RF,   3'b001));
    vecs.push_back(mk("sim_done",  0, 0,  0,1,0,0,0, 10, 0, S_AD,   3'b001));
    vecs.push_back(mk("sim_dr5",   0, 0,  0,0,0,0,0, 5,  0, S_AD,   3'b001));
    vecs.push_back(mk("sim_dr0",   0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b001));
    vecs.push_back(mk("sim_pend",  0, 0,  0,0,0,0,0, 0,  0, S_AF,   3'b000));
    vecs.push_back(mk("sim_o15",   0, 0,  0,0,0,0,0, 15, 0, S_AF,   3'b000));
    vecs.push_back(mk("sim_o16",   0, 0,  0,0,0,0,0, 16, 0, S_TW,   3'b000));
    vecs.push_back(mk("sim_txs",   0, 0,  0,0,0,1,0, 16, 0, S_TD,   3'b000));
    vecs.push_back(mk("sim_txd",   0, 0,  0,0,0,0,1, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("ab_start",  0, 0,  1,0,0,0,0, 0,  0, S_RF,   3'b000));
    vecs.push_back(mk("ab_fill",   0, 0,  0,0,0,0,0, 12, 0, S_RF,   3'b000));
    vecs.push_back(mk("ab_err",    0, 0,  0,0,1,0,0, 12, 0, S_IDLE, 3'b010));
    vecs.push_back(mk("ab_once",   0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("de_start",  0, 0,  1,0,0,0,0, 0,  0, S_RF,   3'b000));
    vecs.push_back(mk("de_both",   0, 0,  0,1,1,0,0, 3,  0, S_IDLE, 3'b010));
    vecs.push_back(mk("de_after",  0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("cl_start",  1, 100,0,0,0,0,0, 0,  0, S_AF,   3'b000));
    vecs.push_back(mk("cl_o63",    0, 0,  0,0,0,0,0, 63, 0, S_AF,   3'b000));
    vecs.push_back(mk("cl_o64",    0, 0,  0,0,0,0,0, 64, 0, S_TW,   3'b000));
    vecs.push_back(mk("fl_tw",     0, 0,  0,0,0,0,0, 64, 1, S_IDLE, 3'b010));
    vecs.push_back(mk("fl_tw_clr", 0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("zl_start",  1, 0,  0,0,0,0,0, 0,  0, S_AF,   3'b000));
    vecs.push_back(mk("zl_exit",   0, 0,  0,0,0,0,0, 0,  0, S_TW,   3'b000));
    vecs.push_back(mk("zl_txs",    0, 0,  0,0,0,1,0, 0,  0, S_TD,   3'b000));
    vecs.push_back(mk("fd_pend",   1, 5,  0,0,0,0,0, 0,  0, S_TD,   3'b001));
    vecs.push_back(mk("fd_flush",  0, 0,  0,0,0,0,0, 0,  1, S_IDLE, 3'b010));
    vecs.push_back(mk("fd_stay",   0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("ft_start",  1, 3,  0,0,0,0,0, 0,  0, S_AF,   3'b000));
    vecs.push_back(mk("ft_both",   1, 9,  0,0,0,0,0, 0,  1, S_IDLE, 3'b010));
    vecs.push_back(mk("ft_after",  0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("b2b_nak1",  0, 0,  0,0,0,1,0, 0,  0, S_IDLE, 3'b100));
    vecs.push_back(mk("b2b_nak2",  0, 0,  0,0,0,1,0, 0,  0, S_IDLE, 3'b100));
    vecs.push_back(mk("b2b_nak0",  0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b000));
    vecs.push_back(mk("b2b_fl1",   0, 0,  0,0,0,0,0, 0,  1, S_IDLE, 3'b010));
    vecs.push_back(mk("b2b_fl2",   0, 0,  0,0,0,0,0, 0,  1, S_IDLE, 3'b010));
    vecs.push_back(mk("b2b_fl0",   0, 0,  0,0,0,0,0, 0,  0, S_IDLE, 3'b000));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRst = 1'b0;
    #12;
    check("reset_state", obs, 9'b0);
    @(posedge clk);
    #1 nRst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].tpsc, vecs[i].size, vecs[i].rxs, vecs[i].rxd, vecs[i].rxe,
            vecs[i].txs, vecs[i].txd, vecs[i].occ, vecs[i].fl);
      @(posedge clk);
      #1 check(vecs[i].name, obs, vecs[i].exp);
    end

    // Reset asserted mid-RX with a pending request: everything clears without a clock edge.
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("rst_rx_enter", obs, {S_RF, 3'b000});
    drive(1, 7, 0, 0, 0, 0, 0, 6, 0);
    @(posedge clk);
    #1 check("rst_rx_pend", obs, {S_RF, 3'b001});
    drive(0, 0, 0, 0, 0, 0, 0, 6, 0);
    #2 nRst = 1'b0;
    #1 check("rst_async", obs, 9'b0);
    @(posedge clk);
    #1 nRst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("rst_no_flush", obs, 9'b0);

    // Randomized traffic against the reference model.
    do_reset();
    mState = M_IDLE; mSize = 0; mPend = 0; mNak = 0; mBfl = 0;
    for (int c = 0; c < 3000; c++) begin
      bit tpsc = ($urandom_range(0, 7) == 0);
      int size = ($urandom_range(0, 3) == 0) ? $urandom_range(65, 127) : $urandom_range(0, 64);
      bit rxs  = ($urandom_range(0, 5) == 0);
      bit rxd  = ($urandom_range(0, 4) == 0);
      bit rxe  = ($urandom_range(0, 9) == 0);
      bit txs  = ($urandom_range(0, 4) == 0);
      bit txd  = ($urandom_range(0, 4) == 0);
      bit fl   = ($urandom_range(0, 49) == 0);
      int occ  = $urandom_range(0, 64);
      if (mState == M_AHB_FILL && $urandom_range(0, 1) == 0) occ = mSize;
      if (mState == M_AHB_DRAIN && $urandom_range(0, 2) == 0) occ = 0;
      drive(tpsc, 7'(size), rxs, rxd, rxe, txs, txd, 7'(occ), fl);
      model_step(tpsc, size, rxs, rxd, rxe, txs, txd, occ, fl);
      @(posedge clk);
      #1 check($sformatf("rand_%0d", c), obs, {state_view(mState), mNak, mBfl, mPend});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
